// File: rtl/dp_unstuff.sv
// DisplayPort receive deframer: tracks blanking / transfer-unit framing on
// descrambled lane symbols, drops fill and repacks 24 bpp pixels into pairs.
module dp_unstuff #(
  parameter int unsigned CHECKLANES = 1
) (
  input  logic        dpclk,
  input  logic        reset,
  input  logic        twolane,
  input  logic [15:0] rxdat0,
  input  logic [15:0] rxdat1,
  input  logic [1:0]  rxisk0,
  input  logic [1:0]  rxisk1,
  output logic [47:0] pixdat,
  output logic        pixvalid,
  output logic        hstart,
  output logic        vstart,
  output logic        vblank,
  output logic        perr
);

  localparam logic [7:0] K_BS = 8'hBC;
  localparam logic [7:0] K_SR = 8'h1C;
  localparam logic [7:0] K_BE = 8'hFB;
  localparam logic [7:0] K_FS = 8'hFE;
  localparam logic [7:0] K_FE = 8'hF7;

  typedef enum logic [1:0] {BLANK, VBID, ACTIVE, FILL} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [47:0] acc, acc_n;
  logic        line_first, line_first_n;
  logic        vb, vb_n, vbprev, vbprev_n;

  logic        pair_v, pair_h, pair_vs, err;
  logic [47:0] pair_d;

  logic        s1_v, s1_h, s1_vs, s1_err;
  logic [47:0] s1_d;

  // Both symbol slots of a cycle are walked in time order through the
  // framing FSM; lane 0 governs framing and lane 1 rides along in lockstep.
  always_comb begin : deframe
    logic [7:0] s0, s1;
    logic       k0, k1, is_bs, is_be, is_fs, is_fe;
    logic [2:0] last;
    state_n      = state;
    cnt_n        = cnt;
    acc_n        = acc;
    line_first_n = line_first;
    vb_n         = vb;
    vbprev_n     = vbprev;
    pair_v       = 1'b0;
    pair_d       = '0;
    pair_h       = 1'b0;
    pair_vs      = 1'b0;
    err          = 1'b0;
    s0 = '0; s1 = '0; k0 = 1'b0; k1 = 1'b0;
    is_bs = 1'b0; is_be = 1'b0; is_fs = 1'b0; is_fe = 1'b0;
    last = twolane ? 3'd2 : 3'd5;
    for (int i = 0; i < 2; i++) begin
      s0    = rxdat0[8*i +: 8];
      s1    = rxdat1[8*i +: 8];
      k0    = rxisk0[i];
      k1    = rxisk1[i];
      is_bs = k0 && (s0 == K_BS || s0 == K_SR);
      is_be = k0 && (s0 == K_BE);
      is_fs = k0 && (s0 == K_FS);
      is_fe = k0 && (s0 == K_FE);
      if (twolane && CHECKLANES != 0 && (k0 != k1 || (k0 && s0 != s1)))
        err = 1'b1;
      case (state_n)
        VBID: begin
          vbprev_n = vb_n;
          vb_n     = s0[0];
          state_n  = BLANK;
        end
        BLANK: begin
          if (is_bs) state_n = VBID;
          else if (is_be) begin
            state_n      = ACTIVE;
            line_first_n = 1'b1;
          end else if (k0 && !is_fs && !is_fe) err = 1'b1;
        end
        ACTIVE: begin
          if (!k0) begin
            if (twolane) begin
              acc_n[8*int'(cnt_n) +: 8]      = s0;
              acc_n[24 + 8*int'(cnt_n) +: 8] = s1;
            end else begin
              acc_n[8*int'(cnt_n) +: 8] = s0;
            end
            if (cnt_n == last) begin
              pair_v       = 1'b1;
              pair_d       = acc_n;
              pair_h       = line_first_n;
              pair_vs      = line_first_n && vbprev_n && !vb_n;
              line_first_n = 1'b0;
              cnt_n        = '0;
            end else begin
              cnt_n = cnt_n + 3'd1;
            end
          end else if (is_fs) begin
            state_n = FILL;
          end else if (is_bs) begin
            // A line cut short mid-pixel loses its partial pixel.
            if (cnt_n != 3'd0) err = 1'b1;
            cnt_n   = '0;
            state_n = VBID;
          end else begin
            err = 1'b1;
          end
        end
        default: begin
          if (k0) begin
            if (is_fe) state_n = ACTIVE;
            else if (is_bs) begin
              err     = 1'b1;
              cnt_n   = '0;
              state_n = VBID;
            end else err = 1'b1;
          end
        end
      endcase
    end
  end

  // Stage 1: framing state, pixel accumulator and the completed pair.
  always_ff @(posedge dpclk or negedge reset) begin
    if (!reset) begin
      state      <= BLANK;
      cnt        <= '0;
      acc        <= '0;
      line_first <= 1'b0;
      vb         <= 1'b0;
      vbprev     <= 1'b1;
      s1_v       <= 1'b0;
      s1_d       <= '0;
      s1_h       <= 1'b0;
      s1_vs      <= 1'b0;
      s1_err     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      line_first <= line_first_n;
      vb         <= vb_n;
      vbprev     <= vbprev_n;
      s1_v       <= pair_v;
      s1_d       <= pair_d;
      s1_h       <= pair_h;
      s1_vs      <= pair_vs;
      s1_err     <= err;
    end
  end

  // Stage 2: output register.
  always_ff @(posedge dpclk or negedge reset) begin
    if (!reset) begin
      pixdat   <= '0;
      pixvalid <= 1'b0;
      hstart   <= 1'b0;
      vstart   <= 1'b0;
      vblank   <= 1'b0;
      perr     <= 1'b0;
    end else begin
      pixdat   <= s1_d;
      pixvalid <= s1_v;
      hstart   <= s1_v && s1_h;
      vstart   <= s1_v && s1_vs;
      vblank   <= vb;
      perr     <= s1_err;
    end
  end

endmodule

// File: tb/tb_dp_unstuff.sv
// Self-checking bench for dp_unstuff: directed scenarios plus random framing
// streams compared cycle-by-cycle against a queue-based symbol model.
module tb_dp_unstuff;

  logic        dpclk = 1'b0;
  logic        reset;
  logic        twolane;
  logic [15:0] rxdat0, rxdat1;
  logic [1:0]  rxisk0, rxisk1;
  logic [47:0] pixdat;
  logic        pixvalid, hstart, vstart, vblank, perr;

  dp_unstuff dut (
    .dpclk(dpclk), .reset(reset), .twolane(twolane),
    .rxdat0(rxdat0), .rxdat1(rxdat1), .rxisk0(rxisk0), .rxisk1(rxisk1),
    .pixdat(pixdat), .pixvalid(pixvalid), .hstart(hstart), .vstart(vstart),
    .vblank(vblank), .perr(perr)
  );

  always #5 dpclk = ~dpclk;

  typedef struct packed {
    logic        v;
    logic [47:0] d;
    logic        h;
    logic        vs;
    logic        vbl;
    logic        err;
  } exp_t;

  int total = 0;
  int bad   = 0;

  exp_t        expq[$];
  exp_t        cur;
  logic [8:0]  s0q[$], s1q[$];
  logic [47:0] pix_log[$];
  int          npix, npe;

  // Reference model: symbol-level framing with byte queues per lane.
  int          m_mode;
  logic [7:0]  m_q0[$], m_q1[$];
  bit          m_first, m_vb, m_vbp;

  task automatic model_reset();
    m_mode = 0; m_q0.delete(); m_q1.delete();
    m_first = 0; m_vb = 0; m_vbp = 1;
  endtask

  task automatic model_slot(input logic [8:0] a, input logic [8:0] b);
    logic [7:0] c  = a[7:0];
    bit         k  = a[8];
    bit         bs = k && (c == 8'hBC || c == 8'h1C);
    bit         be = k && (c == 8'hFB);
    bit         fs = k && (c == 8'hFE);
    bit         fe = k && (c == 8'hF7);
    int         need = twolane ? 3 : 6;
    if (twolane && (a[8] !== b[8] || (a[8] && c !== b[7:0]))) cur.err = 1'b1;
    case (m_mode)
      1: begin m_vbp = m_vb; m_vb = c[0]; m_mode = 0; end
      0: begin
        if (bs) m_mode = 1;
        else if (be) begin m_mode = 2; m_first = 1; end
        else if (k && !fs && !fe) cur.err = 1'b1;
      end
      2: begin
        if (!k) begin
          m_q0.push_back(c);
          m_q1.push_back(b[7:0]);
          if (m_q0.size() == need) begin
            cur.v  = 1'b1;
            cur.h  = m_first;
            cur.vs = m_first && m_vbp && !m_vb;
            if (twolane) cur.d = {m_q1[2], m_q1[1], m_q1[0], m_q0[2], m_q0[1], m_q0[0]};
            else         cur.d = {m_q0[5], m_q0[4], m_q0[3], m_q0[2], m_q0[1], m_q0[0]};
            m_first = 0;
            m_q0.delete(); m_q1.delete();
          end
        end else if (fs) m_mode = 3;
        else if (bs) begin
          if (m_q0.size() != 0) cur.err = 1'b1;
          m_q0.delete(); m_q1.delete();
          m_mode = 1;
        end else cur.err = 1'b1;
      end
      default: begin
        if (k) begin
          if (fe) m_mode = 2;
          else if (bs) begin
            cur.err = 1'b1;
            m_q0.delete(); m_q1.delete();
            m_mode = 1;
          end else cur.err = 1'b1;
        end
      end
    endcase
  endtask

  // One symbol-clock step: compare outputs owed from two cycles ago, then drive.
  task automatic cycle(input logic [15:0] d0, input logic [15:0] d1,
                       input logic [1:0] k0, input logic [1:0] k1);
    exp_t e;
    if (pixvalid === 1'b1) begin npix++; pix_log.push_back(pixdat); end
    if (perr === 1'b1) npe++;
    if (expq.size() == 2) begin
      e = expq.pop_front();
      total++;
      if (pixvalid !== e.v) begin
        bad++; $display("[TB] FAIL pixvalid got=%0b want=%0b t=%0t", pixvalid, e.v, $time);
      end
      total++;
      if (perr !== e.err) begin
        bad++; $display("[TB] FAIL perr got=%0b want=%0b t=%0t", perr, e.err, $time);
      end
      total++;
      if (vblank !== e.vbl) begin
        bad++; $display("[TB] FAIL vblank got=%0b want=%0b t=%0t", vblank, e.vbl, $time);
      end
      if (e.v) begin
        total++;
        if (pixdat !== e.d) begin
          bad++; $display("[TB] FAIL pixdat got=%h want=%h t=%0t", pixdat, e.d, $time);
        end
        total++;
        if (hstart !== e.h) begin
          bad++; $display("[TB] FAIL hstart got=%0b want=%0b t=%0t", hstart, e.h, $time);
        end
        total++;
        if (vstart !== e.vs) begin
          bad++; $display("[TB] FAIL vstart got=%0b want=%0b t=%0t", vstart, e.vs, $time);
        end
      end
    end
    rxdat0 = d0; rxdat1 = d1; rxisk0 = k0; rxisk1 = k1;
    cur = '0;
    model_slot({k0[0], d0[7:0]},  {k1[0], d1[7:0]});
    model_slot({k0[1], d0[15:8]}, {k1[1], d1[15:8]});
    cur.vbl = m_vb;
    expq.push_back(cur);
    @(negedge dpclk);
  endtask

  task automatic do_reset(input logic tl);
    reset = 1'b0; twolane = tl;
    rxdat0 = '0; rxdat1 = '0; rxisk0 = '0; rxisk1 = '0;
    repeat (2) @(negedge dpclk);
    expq.delete();
    model_reset();
    reset = 1'b1;
  endtask

  task automatic kk(input logic [7:0] b);
    s0q.push_back({1'b1, b}); s1q.push_back({1'b1, b});
  endtask
  task automatic dd(input logic [7:0] b);
    s0q.push_back({1'b0, b}); s1q.push_back({1'b0, b ^ 8'h5A});
  endtask
  task automatic d2(input logic [7:0] a, input logic [7:0] b);
    s0q.push_back({1'b0, a}); s1q.push_back({1'b0, b});
  endtask

  task automatic run_stream();
    logic [8:0] a0, a1, b0, b1;
    while (s0q.size() % 2 != 0) begin s0q.push_back(9'h000); s1q.push_back(9'h000); end
    while (s0q.size() > 0) begin
      a0 = s0q.pop_front(); b0 = s0q.pop_front();
      a1 = s1q.pop_front(); b1 = s1q.pop_front();
      cycle({b0[7:0], a0[7:0]}, {b1[7:0], a1[7:0]}, {b0[8], a0[8]}, {b1[8], a1[8]});
    end
    repeat (3) cycle('0, '0, '0, '0);
  endtask

  task automatic start_counts();
    npix = 0; npe = 0; pix_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; twolane = 1'b0;
    rxdat0 = 16'hFBBC; rxdat1 = 16'hFBBC; rxisk0 = 2'b11; rxisk1 = 2'b11;
    repeat (3) @(negedge dpclk);
    total++; if (pixvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pixvalid got=%0b want=0", pixvalid); end
    total++; if (pixdat !== 48'h0) begin bad++; $display("[TB] FAIL reset_pixdat got=%h want=0", pixdat); end
    total++; if (hstart !== 1'b0) begin bad++; $display("[TB] FAIL reset_hstart got=%0b want=0", hstart); end
    total++; if (vstart !== 1'b0) begin bad++; $display("[TB] FAIL reset_vstart got=%0b want=0", vstart); end
    total++; if (vblank !== 1'b0) begin bad++; $display("[TB] FAIL reset_vblank got=%0b want=0", vblank); end
    total++; if (perr !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr got=%0b want=0", perr); end
  endtask

  task automatic test_single_lane();
    do_reset(1'b0); start_counts();
    kk(8'hBC); dd(8'h01); kk(8'hBC); dd(8'h00); kk(8'hFB);
    for (int i = 1; i <= 12; i++) dd(8'(i));
    kk(8'hBC); dd(8'h00);
    run_stream();
    total++; if (npix !== 2) begin bad++; $display("[TB] FAIL single_count got=%0d want=2", npix); end
    total++; if (pix_log.size() < 1 || pix_log[0] !== 48'h060504030201) begin
      bad++; $display("[TB] FAIL single_pair0 got=%h want=060504030201", pix_log.size() ? pix_log[0] : 48'h0);
    end
    total++; if (npe !== 0) begin bad++; $display("[TB] FAIL single_perr got=%0d want=0", npe); end
  endtask

  task automatic test_two_lane();
    do_reset(1'b1); start_counts();
    kk(8'hBC); d2(8'h01, 8'h01); kk(8'hBC); d2(8'h00, 8'h00); kk(8'hFB);
    d2(8'h11, 8'hA1); d2(8'h22, 8'hB2); d2(8'h33, 8'hC3);
    kk(8'hBC); d2(8'h00, 8'h00);
    run_stream();
    total++; if (pix_log.size() != 1 || pix_log[0] !== 48'hC3B2A1332211) begin
      bad++; $display("[TB] FAIL twolane_pair got=%h n=%0d want=c3b2a1332211 n=1", pix_log.size() ? pix_log[0] : 48'h0, pix_log.size());
    end
  endtask

  task automatic test_fill();
    do_reset(1'b0); start_counts();
    kk(8'hBC); dd(8'h00); kk(8'hFB); dd(8'h01); dd(8'h02); kk(8'hFE);
    repeat (5) dd(8'h00);
    kk(8'hF7);
    for (int i = 3; i <= 6; i++) dd(8'(i));
    kk(8'hBC); dd(8'h00);
    run_stream();
    total++; if (pix_log.size() != 1 || pix_log[0] !== 48'h060504030201) begin
      bad++; $display("[TB] FAIL fill_pair got=%h n=%0d want=060504030201 n=1", pix_log.size() ? pix_log[0] : 48'h0, pix_log.size());
    end
    total++; if (npe !== 0) begin bad++; $display("[TB] FAIL fill_perr got=%0d want=0", npe); end
  endtask

  task automatic test_truncated();
    do_reset(1'b0); start_counts();
    kk(8'hBC); dd(8'h00); kk(8'hFB);
    repeat (4) dd(8'hEE);
    kk(8'hBC); dd(8'h00); kk(8'hFB);
    for (int i = 1; i <= 6; i++) dd(8'(i + 8'h20));
    kk(8'hBC); dd(8'h00);
    run_stream();
    total++; if (npe !== 1) begin bad++; $display("[TB] FAIL trunc_perr got=%0d want=1", npe); end
    total++; if (pix_log.size() != 1 || pix_log[0] !== 48'h262524232221) begin
      bad++; $display("[TB] FAIL trunc_pair got=%h n=%0d want=262524232221 n=1", pix_log.size() ? pix_log[0] : 48'h0, pix_log.size());
    end
  endtask

  task automatic test_bad_k();
    do_reset(1'b0); start_counts();
    kk(8'hBC); dd(8'h00); kk(8'hFB); dd(8'h01); kk(8'h3C);
    for (int i = 2; i <= 6; i++) dd(8'(i));
    kk(8'hBC); dd(8'h00);
    run_stream();
    total++; if (npe !== 1) begin bad++; $display("[TB] FAIL badk_perr got=%0d want=1", npe); end
    total++; if (pix_log.size() != 1 || pix_log[0] !== 48'h060504030201) begin
      bad++; $display("[TB] FAIL badk_pair got=%h want=060504030201", pix_log.size() ? pix_log[0] : 48'h0);
    end
    do_reset(1'b1); start_counts();
    s0q.push_back({1'b1, 8'hBC}); s1q.push_back({1'b0, 8'hBC});
    d2(8'h00, 8'h00);
    run_stream();
    total++; if (npe !== 1) begin bad++; $display("[TB] FAIL lanemis_perr got=%0d want=1", npe); end
  endtask

  task automatic test_reset_midline();
    do_reset(1'b0); start_counts();
    kk(8'hBC); dd(8'h00); kk(8'hFB); dd(8'h41); dd(8'h42); dd(8'h43);
    run_stream();
    do_reset(1'b0); start_counts();
    repeat (4) dd(8'h77);
    kk(8'hFB);
    for (int i = 1; i <= 6; i++) dd(8'(i + 8'h50));
    kk(8'hBC); dd(8'h00);
    run_stream();
    total++; if (pix_log.size() != 1 || pix_log[0] !== 48'h565554535251) begin
      bad++; $display("[TB] FAIL midreset_pair got=%h n=%0d want=565554535251 n=1", pix_log.size() ? pix_log[0] : 48'h0, pix_log.size());
    end
  endtask

  task automatic test_random();
    int r;
    for (int run = 0; run < 6; run++) begin
      do_reset(1'(run % 2));
      for (int ln = 0; ln < 8; ln++) begin
        kk(($urandom_range(0, 3) == 0) ? 8'h1C : 8'hBC);
        d2(8'($urandom_range(0, 1)), 8'h00);
        if (twolane) s1q[s1q.size()-1] = s0q[s0q.size()-1];
        kk(8'hFB);
        for (int s = 0; s < int'($urandom_range(6, 36)); s++) begin
          r = $urandom_range(0, 99);
          if (r < 75) begin
            d2(8'($urandom), 8'($urandom));
          end else if (r < 85) begin
            kk(8'hFE);
            repeat ($urandom_range(0, 3)) dd(8'h00);
            kk(8'hF7);
          end else if (r < 88) begin
            kk(8'h3C);
          end else if (r < 90) begin
            kk(($urandom_range(0, 1) == 1) ? 8'hFB : 8'hF7);
          end else if (r < 92) begin
            s0q.push_back({1'b0, 8'($urandom)}); s1q.push_back({1'b1, 8'hBC});
          end else if (!twolane) begin
            s0q.push_back({1'b0, 8'($urandom)}); s1q.push_back(9'($urandom));
          end else begin
            d2(8'($urandom), 8'($urandom));
          end
        end
      end
      kk(8'hBC); dd(8'h00);
      run_stream();
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_two_lane();
    test_fill();
    test_truncated();
    test_bad_k();
    test_reset_midline();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
